// File: rtl/alu_control_pipe_pkg.sv
// Shared definitions for the ALU control pipeline stage.
//   - 4-bit ALU operation codes used by this stage and by the datapath ALU
//   - 2-bit ALUOp encodings produced by the main decoder
//   - sequencer state type
//   - base integer funct3 lookup shared by the R-type and I-type paths
package alu_control_pipe_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_MULH = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REM  = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MC_WAIT = 1'b1
    } mc_state_e;

    // Base integer op from funct3; funct7_5 only selects SRA over SRL here.
    function automatic logic [3:0] base_op(input logic [2:0] f3, input logic f7_5);
        logic [3:0] op;
        case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = f7_5 ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            3'b111:  op = OP_AND;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_control_pipe_decode.sv
// alu_op_decode: combinational ALU control decode.
// Ports:
//   alu_op   [1:0] in  : 00 load/store, 01 branch, 10 R-type, 11 I-type
//   funct3   [2:0] in  : instruction funct3
//   funct7_5       in  : instruction bit 30 (SUB/SRA select)
//   funct7_0       in  : instruction bit 25 (M-extension select)
//   op       [3:0] out : ALU operation code (ADD when illegal)
//   illegal        out : encoding not supported
//   is_mul         out : legal MUL/MULH
//   is_div         out : legal DIV/DIVU/REM/REMU
module alu_op_decode
    import alu_control_pipe_pkg::*;
#(
    parameter bit M_EXT = 1'b1
) (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       funct7_0,
    output logic [3:0] op,
    output logic       illegal,
    output logic       is_mul,
    output logic       is_div
);

    // Decode ALUOp/funct fields into an operation and its class flags.
    always_comb begin
        op      = OP_ADD;
        illegal = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (alu_op)
            ALUOP_MEM:    op = OP_ADD;
            ALUOP_BRANCH: op = OP_SUB;
            ALUOP_ITYPE:  op = base_op(funct3, funct7_5);
            ALUOP_RTYPE: begin
                if (funct7_0) begin
                    // bit 30 and bit 25 together never form a valid encoding
                    if (funct7_5 || !M_EXT) begin
                        illegal = 1'b1;
                    end else begin
                        case (funct3)
                            3'b000:  begin op = OP_MUL;  is_mul = 1'b1; end
                            3'b001:  begin op = OP_MULH; is_mul = 1'b1; end
                            3'b100:  begin op = OP_DIV;  is_div = 1'b1; end
                            3'b101:  begin op = OP_DIVU; is_div = 1'b1; end
                            3'b110:  begin op = OP_REM;  is_div = 1'b1; end
                            3'b111:  begin op = OP_REMU; is_div = 1'b1; end
                            default: illegal = 1'b1;
                        endcase
                    end
                end else if (funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                    illegal = 1'b1;
                end else if (funct7_5 && (funct3 == 3'b000)) begin
                    op = OP_SUB;
                end else begin
                    op = base_op(funct3, funct7_5);
                end
            end
            default: op = OP_ADD;
        endcase
        // Illegal encodings always fall back to a harmless single-cycle ADD.
        if (illegal) begin
            op = OP_ADD;
        end else begin
            op = op;
        end
    end

endmodule

// File: rtl/alu_control_pipe.sv
// alu_control_pipe: registered ALU control at the ID/EX boundary.
// Decodes ALUOp/funct fields, registers the operation and, for M-extension
// ops, holds it for a fixed latency while reporting busy/done to the hazard
// unit.
// Ports:
//   clk, reset (async, active high)
//   valid_in, alu_op[1:0], funct3[2:0], funct7_5, funct7_0 : decode inputs
//   stall_in : downstream hold (only effective in IDLE)
//   flush    : synchronous squash
//   operation[3:0], op_valid, illegal : registered results
//   mc_busy  : multi-cycle op in flight, upstream must stall
//   mc_done  : single-cycle pulse in the last multi-cycle cycle
module alu_control_pipe
    import alu_control_pipe_pkg::*;
#(
    parameter bit M_EXT      = 1'b1,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       funct7_0,
    input  logic       stall_in,
    input  logic       flush,
    output logic [3:0] operation,
    output logic       op_valid,
    output logic       illegal,
    output logic       mc_busy,
    output logic       mc_done
);

    // Counter preload is latency-1 so that the final busy cycle sees cnt==0.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    logic [3:0] dec_op_s;
    logic       dec_illegal_s;
    logic       dec_is_mul_s;
    logic       dec_is_div_s;

    mc_state_e  state_r;
    logic [5:0] cnt_r;
    logic [3:0] operation_r;
    logic       op_valid_r;
    logic       illegal_r;

    alu_op_decode #(
        .M_EXT(M_EXT)
    ) u_decode (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .funct7_0 (funct7_0),
        .op       (dec_op_s),
        .illegal  (dec_illegal_s),
        .is_mul   (dec_is_mul_s),
        .is_div   (dec_is_div_s)
    );

    // Operation registers, sequencer state and latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 6'd0;
            operation_r <= OP_ADD;
            op_valid_r  <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 6'd0;
            operation_r <= OP_ADD;
            op_valid_r  <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (stall_in) begin
                        state_r <= ST_IDLE;
                    end else if (valid_in) begin
                        operation_r <= dec_op_s;
                        illegal_r   <= dec_illegal_s;
                        op_valid_r  <= 1'b1;
                        if (dec_is_mul_s) begin
                            state_r <= ST_MC_WAIT;
                            cnt_r   <= MUL_LOAD;
                        end else if (dec_is_div_s) begin
                            state_r <= ST_MC_WAIT;
                            cnt_r   <= DIV_LOAD;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        op_valid_r <= 1'b0;
                    end
                end
                ST_MC_WAIT: begin
                    // Inputs and stall_in are ignored while the op is in flight.
                    if (cnt_r == 6'd0) begin
                        state_r    <= ST_IDLE;
                        op_valid_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 6'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= 6'd0;
                    op_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign operation = operation_r;
    assign op_valid  = op_valid_r;
    assign illegal   = illegal_r;
    assign mc_busy   = (state_r == ST_MC_WAIT);
    // A flush in the last cycle suppresses the completion pulse.
    assign mc_done   = (state_r == ST_MC_WAIT) && (cnt_r == 6'd0) && !flush;

endmodule

// File: tb/tb_alu_control_pipe.sv
module tb_alu_control_pipe;

    logic       clk;
    logic       reset;
    logic       valid_in;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       funct7_0;
    logic       stall_in;
    logic       flush;

    logic [3:0] a_operation, b_operation;
    logic       a_op_valid, b_op_valid;
    logic       a_illegal, b_illegal;
    logic       a_mc_busy, b_mc_busy;
    logic       a_mc_done, b_mc_done;

    int nvec;
    int nerr;

    alu_control_pipe #(.M_EXT(1'b1), .MUL_CYCLES(3), .DIV_CYCLES(33)) dut_a (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op),
        .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .stall_in(stall_in), .flush(flush),
        .operation(a_operation), .op_valid(a_op_valid), .illegal(a_illegal),
        .mc_busy(a_mc_busy), .mc_done(a_mc_done)
    );

    alu_control_pipe #(.M_EXT(1'b0), .MUL_CYCLES(3), .DIV_CYCLES(33)) dut_b (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op),
        .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .stall_in(stall_in), .flush(flush),
        .operation(b_operation), .op_valid(b_op_valid), .illegal(b_illegal),
        .mc_busy(b_mc_busy), .mc_done(b_mc_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic f75, input logic f70);
        valid_in = v;
        alu_op   = op;
        funct3   = f3;
        funct7_5 = f75;
        funct7_0 = f70;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        clk = 1'b0;
        reset = 1'b1;
        stall_in = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_op",    {4'h0, a_operation}, 8'h02);
        chk("rst_valid", {7'h0, a_op_valid},  8'h00);
        chk("rst_ill",   {7'h0, a_illegal},   8'h00);
        chk("rst_busy",  {7'h0, a_mc_busy},   8'h00);
        chk("rst_done",  {7'h0, a_mc_done},   8'h00);
        reset = 1'b0;
        tick();

        // R-type SUB, then same encoding as I-type gives ADD
        drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b0);
        tick();
        chk("sub_op",    {4'h0, a_operation}, 8'h06);
        chk("sub_valid", {7'h0, a_op_valid},  8'h01);
        chk("sub_busy",  {7'h0, a_mc_busy},   8'h00);
        drive(1'b1, 2'b11, 3'b000, 1'b1, 1'b0);
        tick();
        chk("addi_op",   {4'h0, a_operation}, 8'h02);
        chk("addi_busy", {7'h0, a_mc_busy},   8'h00);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        tick();
        chk("idle_valid", {7'h0, a_op_valid},  8'h00);
        chk("idle_hold",  {4'h0, a_operation}, 8'h02);

        // assorted decodes
        drive(1'b1, 2'b10, 3'b101, 1'b1, 1'b0);
        tick();
        chk("sra_op", {4'h0, a_operation}, 8'h05);
        drive(1'b1, 2'b11, 3'b101, 1'b0, 1'b0);
        tick();
        chk("srli_op", {4'h0, a_operation}, 8'h04);
        drive(1'b1, 2'b10, 3'b010, 1'b1, 1'b0);
        tick();
        chk("rill_op",  {4'h0, a_operation}, 8'h02);
        chk("rill_ill", {7'h0, a_illegal},   8'h01);
        drive(1'b1, 2'b01, 3'b111, 1'b0, 1'b0);
        tick();
        chk("br_op",  {4'h0, a_operation}, 8'h06);
        chk("br_ill", {7'h0, a_illegal},   8'h00);
        drive(1'b1, 2'b11, 3'b011, 1'b0, 1'b0);
        tick();
        chk("sltiu_op", {4'h0, a_operation}, 8'h09);
        drive(1'b1, 2'b10, 3'b111, 1'b0, 1'b0);
        tick();
        chk("and_op", {4'h0, a_operation}, 8'h00);
        drive(1'b1, 2'b10, 3'b011, 1'b0, 1'b1);
        tick();
        chk("m011_op",   {4'h0, a_operation}, 8'h02);
        chk("m011_ill",  {7'h0, a_illegal},   8'h01);
        chk("m011_busy", {7'h0, a_mc_busy},   8'h00);
        drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b1);
        tick();
        chk("f7both_ill", {7'h0, a_illegal}, 8'h01);

        // MUL on M_EXT=1 with flush in cycle 2; same encoding illegal on M_EXT=0
        drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b1);
        tick();
        chk("mul_op",    {4'h0, a_operation}, 8'h0a);
        chk("mul_busy",  {7'h0, a_mc_busy},   8'h01);
        chk("mul_done1", {7'h0, a_mc_done},   8'h00);
        chk("nom_op",    {4'h0, b_operation}, 8'h02);
        chk("nom_ill",   {7'h0, b_illegal},   8'h01);
        chk("nom_busy",  {7'h0, b_mc_busy},   8'h00);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        tick();
        chk("mul_busy2", {7'h0, a_mc_busy}, 8'h01);
        flush = 1'b1;
        #1;
        chk("fl_done", {7'h0, a_mc_done}, 8'h00);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_valid", {7'h0, a_op_valid},  8'h00);
        chk("fl_busy",  {7'h0, a_mc_busy},   8'h00);
        chk("fl_done2", {7'h0, a_mc_done},   8'h00);
        chk("fl_op",    {4'h0, a_operation}, 8'h02);
        chk("fl_ill_b", {7'h0, b_illegal},   8'h00);
        drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0);
        tick();
        chk("postfl_valid", {7'h0, a_op_valid}, 8'h01);
        chk("postfl_busy",  {7'h0, a_mc_busy},  8'h00);

        // full MULH run: done only in 3rd busy cycle
        drive(1'b1, 2'b10, 3'b001, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            chk("mulh_busy",  {7'h0, a_mc_busy},   8'h01);
            chk("mulh_done",  {7'h0, a_mc_done},   (k == 3) ? 8'h01 : 8'h00);
            chk("mulh_valid", {7'h0, a_op_valid},  8'h01);
            chk("mulh_op",    {4'h0, a_operation}, 8'h0b);
            tick();
        end
        chk("mulh_end_valid", {7'h0, a_op_valid}, 8'h00);
        chk("mulh_end_busy",  {7'h0, a_mc_busy},  8'h00);

        // DIV with a new valid op held high during the whole wait
        drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b1);
        tick();
        drive(1'b1, 2'b11, 3'b100, 1'b0, 1'b0);
        for (int k = 1; k <= 33; k++) begin
            chk("div_busy", {7'h0, a_mc_busy},   8'h01);
            chk("div_done", {7'h0, a_mc_done},   (k == 33) ? 8'h01 : 8'h00);
            chk("div_op",   {4'h0, a_operation}, 8'h0c);
            tick();
        end
        chk("div_end_valid", {7'h0, a_op_valid},  8'h00);
        chk("div_end_busy",  {7'h0, a_mc_busy},   8'h00);
        chk("div_end_op",    {4'h0, a_operation}, 8'h0c);
        tick();
        chk("xor_op",    {4'h0, a_operation}, 8'h03);
        chk("xor_valid", {7'h0, a_op_valid},  8'h01);

        // stall holds an accepted SLL for 3 cycles
        drive(1'b1, 2'b11, 3'b001, 1'b0, 1'b0);
        tick();
        chk("sll_op", {4'h0, a_operation}, 8'h08);
        drive(1'b1, 2'b11, 3'b110, 1'b0, 1'b0);
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_op",    {4'h0, a_operation}, 8'h08);
            chk("stall_valid", {7'h0, a_op_valid},  8'h01);
        end
        stall_in = 1'b0;
        tick();
        chk("unstall_op",    {4'h0, a_operation}, 8'h01);
        chk("unstall_valid", {7'h0, a_op_valid},  8'h01);

        // async reset in the middle of a DIV
        drive(1'b1, 2'b10, 3'b110, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        chk("prerst_busy", {7'h0, a_mc_busy}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_op",    {4'h0, a_operation}, 8'h02);
        chk("arst_valid", {7'h0, a_op_valid},  8'h00);
        chk("arst_busy",  {7'h0, a_mc_busy},   8'h00);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("postrst_op",    {4'h0, a_operation}, 8'h02);
        chk("postrst_valid", {7'h0, a_op_valid},  8'h00);
        chk("postrst_busy",  {7'h0, a_mc_busy},   8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_control_pipe.md
Name: alu_control_pipe

Overview:
- Registered, parametrised successor to the combinational ALU control unit, sitting in the ID/EX boundary of the RV32 pipeline.
- Decodes ALUOp, funct3 and funct7 bits into a 4-bit ALU operation for base integer ops (R and I types) and, optionally, RV32M MUL/DIV/REM.
- Holds multi-cycle M-extension ops for a programmable latency and reports busy/done so the hazard unit can stall upstream.

Parameters:
M_EXT, 1, 1 enables MUL/MULH/DIV/DIVU/REM/REMU decode and the multi-cycle sequencer; 0 flags them illegal.
MUL_CYCLES, 3, execute latency of MUL/MULH in cycles; legal range 1..64.
DIV_CYCLES, 33, execute latency of DIV/DIVU/REM/REMU in cycles; legal range 1..64.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  decode inputs valid this cycle
alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
funct3  in  3  instruction funct3
funct7_5  in  1  instruction bit 30
funct7_0  in  1  instruction bit 25 (M-extension select)
stall_in  in  1  downstream hold; freezes outputs in IDLE
flush  in  1  synchronous squash
operation  out  4  registered ALU operation code
op_valid  out  1  operation is valid
illegal  out  1  registered decode-illegal flag for the held op
mc_busy  out  1  multi-cycle op in progress; upstream must stall
mc_done  out  1  one-cycle pulse in the final multi-cycle cycle

Behaviour:
- Reset (async): operation=ADD (0010), op_valid=0, illegal=0, state=IDLE, cnt=0. mc_busy and mc_done are 0.
- Operation codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SRL 0100, SRA 0101, SUB 0110, SLT 0111.
  - SLL 1000, SLTU 1001, MUL 1010, MULH 1011, DIV 1100, DIVU 1101, REM 1110, REMU 1111.
- Decode by alu_op:
  - alu_op=00 → ADD. alu_op=01 → SUB.
  - alu_op=11: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7_5), 110 OR, 111 AND.
  - alu_op=10 with funct7_0=0: same table as alu_op=11, except funct3=000 with funct7_5=1 decodes to SUB.
  - alu_op=10 with funct7_5=1 and funct3 not in {000,101}: illegal.
  - alu_op=10 with funct7_0=1 and M_EXT=1: 000 MUL, 001 MULH, 100 DIV, 101 DIVU, 110 REM, 111 REMU. 010/011 are illegal.
  - funct7_0=1 with M_EXT=0 is illegal. funct7_0=1 with funct7_5=1 is illegal.
  - Illegal decode → operation=ADD, illegal=1, never multi-cycle.
- Accept = valid_in & ~stall_in & ~flush & state==IDLE.
- On accept edge: load operation and illegal, set op_valid=1. If the op is multi-cycle, go to MC_WAIT with cnt=N-1 (N = MUL_CYCLES or DIV_CYCLES).
- IDLE, ~valid_in & ~stall_in: op_valid→0; operation and illegal hold.
- IDLE, stall_in: all registers hold.
- MC_WAIT:
  - mc_busy=1 (combinational from state).
  - cnt decrements every cycle, independent of stall_in. Inputs are ignored.
  - op_valid and operation are held.
  - mc_done = (state==MC_WAIT) & (cnt==0) & ~flush. At that edge: state→IDLE, op_valid→0.
- Latency: accept edge t0. mc_busy is high in cycles t1..tN; mc_done is high in tN. N=1 gives a single busy cycle, which is also the done cycle.
- flush (synchronous, priority below reset): state→IDLE, cnt→0, op_valid→0, illegal→0, operation→ADD. A same-cycle valid_in is dropped. No mc_done is emitted.
- cnt width is 6 bits, sized for 64.

Decomposition:
- Shared include alu_ops.vh: localparams for the 16 operation codes and the ALUOp encodings. The datapath ALU uses the same file.
- One combinational sub-module, alu_op_decode: inputs alu_op, funct3, funct7_5, funct7_0; outputs op, illegal, is_mul, is_div; parameter M_EXT.
- alu_control_pipe holds the registers, the FSM (IDLE, MC_WAIT) and the counter.

Test Plan:
- Reset asserted mid-MC_WAIT → outputs go immediately to operation=0010, op_valid=0, mc_busy=0, and stay there after release.
- alu_op=10, funct3=000, funct7_5=1, valid_in=1 → operation=0110, op_valid=1 next cycle, mc_busy never asserted. The same encoding with alu_op=11 gives 0010.
- alu_op=10, funct7_0=1, funct3=100, DIV_CYCLES=33 → operation=1100; mc_busy high for 33 cycles; mc_done only on the 33rd; op_valid drops the following edge. valid_in held high throughout is not accepted until IDLE.
- M_EXT=0, alu_op=10, funct7_0=1, funct3=000 → operation=0010, illegal=1, no busy.
- stall_in=1 for 3 cycles after an accepted SLL, with new valid_in present → operation stays 1000 and op_valid stays 1; the new op is taken on the first cycle stall_in=0.
- flush asserted at cycle 2 of a MUL (MUL_CYCLES=3) → next cycle op_valid=0, mc_busy=0, no mc_done pulse; a following ADD is accepted normally.
